cla_slice_sequencer: RTL

Multi-cycle wide adder controller. It sits directly upstream and downstream of the 4-bit carry_lookahead_adder: it slices WIDTH-bit operands into 4-bit nibbles and drives them into the adder's A/B/cin inputs one slice per cycle. It captures the adder's S/cout back and assembles a WIDTH-bit sum with carry-out and signed overflow. Valid/ready handshakes on both the operand side and the result side.

---
 rtl/cla_slice_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle wide adder controller around a 4-bit carry-lookahead adder.
// Feeds one operand nibble per cycle and assembles sum, carry-out and overflow.
module cla_slice_sequencer #(
  parameter int WIDTH   = 16,
  parameter int NSLICES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic             busy
);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  localparam int IW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]    idx;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic             a_top;
  logic             b_top;
  logic             ovf_nx;

  assign last = (idx == LAST);

  // Operands shift right one nibble per RUN cycle, so the live slice is
  // always the low nibble; after the last slice the shifters hold zero,
  // which keeps the adder inputs at 0 in DONE and IDLE.
  assign add_a   = a_sh[3:0];
  assign add_b   = b_sh[3:0];
  assign add_cin = carry;

  // Sum nibbles enter at the top of the accumulator and move down.
  assign acc_nx = (acc >> 4) | (WIDTH'(add_s) << (WIDTH - 4));

  // On the final slice the sign bits of A and B sit in the low nibble.
  assign a_top  = a_sh[3];
  assign b_top  = b_sh[3];
  assign ovf_nx = (a_top == b_top) && (add_s[3] != a_top);

  assign sum_out  = sum_q;
  assign cout_out = cout_q;
  assign ovf_out  = ovf_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, slice walk, result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            idx   <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          acc  <= acc_nx;
          if (last) begin
            sum_q  <= acc_nx;
            cout_q <= add_cout;
            ovf_q  <= ovf_nx;
            idx    <= '0;
            // Final carry is kept in cout_q; clearing the running carry
            // holds add_cin low outside RUN.
            carry  <= 1'b0;
          end else begin
            carry <= add_cout;
            idx   <= idx + 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
